// File: rtl/cp_load_sequencer.sv
// Control-plane load sequencer: steers loader beats into state, config and inbound tables, then grants stream-in.
// Latency: one cycle from beat acceptance to the registered write data, address and enable.
// Backpressure: in_ready is high only in the load phases; ready_stream_in is held low until RUN.
module cp_load_sequencer #(
  parameter int phit_size    = 512,
  parameter int dwidth_RFadd = 6,
  parameter int num_col      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_loader,
  input  logic                    start_stream_in,
  input  logic [dwidth_RFadd-1:0] num_entry_state,
  input  logic [dwidth_RFadd-1:0] num_entry_config,
  input  logic [dwidth_RFadd-1:0] num_entry_inbound,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [phit_size-1:0]    in_data,
  output logic [phit_size-1:0]    wr_data,
  output logic                    st_wr_en,
  output logic [num_col-1:0]      cfg_wr_en,
  output logic                    inb_wr_en,
  output logic [dwidth_RFadd-1:0] wr_add,
  output logic                    ready_stream_in,
  output logic                    busy
);

  localparam int COL_W = (num_col > 1) ? $clog2(num_col) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_STATE = 3'd1,
    LD_CFG   = 3'd2,
    LD_INB   = 3'd3,
    RUN      = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [dwidth_RFadd-1:0] cnt_state;
  logic [dwidth_RFadd-1:0] cnt_cfg;
  logic [dwidth_RFadd-1:0] cnt_inb;
  logic [dwidth_RFadd-1:0] cur_cnt;
  logic [dwidth_RFadd-1:0] entry;
  logic [dwidth_RFadd-1:0] entry_nxt;
  logic [COL_W-1:0]        col;
  logic [COL_W-1:0]        col_nxt;
  logic                    accept;
  logic                    last_beat;
  logic                    last_col;

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    in_ready        = (state == LD_STATE) || (state == LD_CFG) || (state == LD_INB);
    ready_stream_in = (state == RUN) && start_stream_in;
    busy            = (state != IDLE);
  end

  // Entry count of the table currently being filled, and end-of-table detection.
  always_comb begin
    cur_cnt = '0;
    case (state)
      LD_STATE: cur_cnt = cnt_state;
      LD_CFG:   cur_cnt = cnt_cfg;
      LD_INB:   cur_cnt = cnt_inb;
      default:  cur_cnt = '0;
    endcase
    accept    = in_valid && in_ready;
    last_beat = accept && ((entry + dwidth_RFadd'(1)) == cur_cnt);
    last_col  = (col == COL_W'(num_col - 1));
  end

  // Next-state, entry index and column index; phase changes happen on the last beat's edge.
  always_comb begin
    state_nxt = state;
    entry_nxt = entry;
    col_nxt   = col;
    case (state)
      IDLE: begin
        if (start_loader) begin
          entry_nxt = '0;
          col_nxt   = '0;
          if (num_entry_state != '0)        state_nxt = LD_STATE;
          else if (num_entry_config != '0)  state_nxt = LD_CFG;
          else if (num_entry_inbound != '0) state_nxt = LD_INB;
          else                              state_nxt = RUN;
        end
      end
      LD_STATE: begin
        if (last_beat) begin
          entry_nxt = '0;
          if (cnt_cfg != '0)      state_nxt = LD_CFG;
          else if (cnt_inb != '0) state_nxt = LD_INB;
          else                    state_nxt = RUN;
        end else if (accept) begin
          entry_nxt = entry + dwidth_RFadd'(1);
        end
      end
      LD_CFG: begin
        if (last_beat) begin
          entry_nxt = '0;
          if (last_col) begin
            state_nxt = (cnt_inb != '0) ? LD_INB : RUN;
          end else begin
            col_nxt = col + COL_W'(1);
          end
        end else if (accept) begin
          entry_nxt = entry + dwidth_RFadd'(1);
        end
      end
      LD_INB: begin
        if (last_beat) begin
          entry_nxt = '0;
          state_nxt = RUN;
        end else if (accept) begin
          entry_nxt = entry + dwidth_RFadd'(1);
        end
      end
      RUN: begin
        if (!start_stream_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Entry/column indices, plus the counts latched once per load on start_loader.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry     <= '0;
      col       <= '0;
      cnt_state <= '0;
      cnt_cfg   <= '0;
      cnt_inb   <= '0;
    end else begin
      entry <= entry_nxt;
      col   <= col_nxt;
      if ((state == IDLE) && start_loader) begin
        cnt_state <= num_entry_state;
        cnt_cfg   <= num_entry_config;
        cnt_inb   <= num_entry_inbound;
      end
    end
  end

  // Write port: data/address captured on accept, enables are single-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_data   <= '0;
      wr_add    <= '0;
      st_wr_en  <= 1'b0;
      cfg_wr_en <= '0;
      inb_wr_en <= 1'b0;
    end else begin
      if (accept) begin
        wr_data <= in_data;
        wr_add  <= entry;
      end
      st_wr_en  <= accept && (state == LD_STATE);
      inb_wr_en <= accept && (state == LD_INB);
      cfg_wr_en <= (accept && (state == LD_CFG)) ? (num_col'(1) << col) : '0;
    end
  end

endmodule

// File: tb/tb_cp_load_sequencer.sv
// Bench for cp_load_sequencer: scenario tasks with random beats against a table-order model.
// Latency: checks each write one cycle after its accepting edge.
// Backpressure: checks in_ready and ready_stream_in against the model phase every cycle.
module tb_cp_load_sequencer;
  localparam int PW   = 512;
  localparam int AW   = 6;
  localparam int NCOL = 6;

  typedef struct packed {
    logic [7:0]    en;   // {st, cfg[5:0], inb}
    logic [AW-1:0] add;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start_loader = 1'b0;
  logic            start_stream_in = 1'b0;
  logic [AW-1:0]   num_entry_state = '0;
  logic [AW-1:0]   num_entry_config = '0;
  logic [AW-1:0]   num_entry_inbound = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [PW-1:0]   in_data = '0;
  logic [PW-1:0]   wr_data;
  logic            st_wr_en;
  logic [NCOL-1:0] cfg_wr_en;
  logic            inb_wr_en;
  logic [AW-1:0]   wr_add;
  logic            ready_stream_in;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  cp_load_sequencer #(.phit_size(PW), .dwidth_RFadd(AW), .num_col(NCOL)) dut (
    .clk(clk), .rst(rst), .start_loader(start_loader), .start_stream_in(start_stream_in),
    .num_entry_state(num_entry_state), .num_entry_config(num_entry_config),
    .num_entry_inbound(num_entry_inbound), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_data(wr_data), .st_wr_en(st_wr_en), .cfg_wr_en(cfg_wr_en),
    .inb_wr_en(inb_wr_en), .wr_add(wr_add), .ready_stream_in(ready_stream_in), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rnd_phit();
    logic [PW-1:0] r;
    for (int k = 0; k < PW / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // One full load: s/c/i counts, vmode 0=always valid, 1=alternating, 2=random;
  // restart_at = accepted-beat count at which a stray start_loader is pulsed (-1 none);
  // abort_at = accepted-beat count at which reset is asserted (-1 none).
  task automatic do_load(input int s, input int c, input int i, input int vmode,
                         input int restart_at, input int abort_at, input bit stream);
    exp_t          q[$];
    logic [PW-1:0] dq[$];
    exp_t          e;
    logic [PW-1:0] d;
    logic [7:0]    obs;
    logic [7:0]    exp_en;
    int            total, acc, cyc;
    bit            pend, done;
    for (int k = 0; k < s; k++) q.push_back('{en: 8'h80, add: AW'(k)});
    for (int cl = 0; cl < NCOL; cl++)
      for (int k = 0; k < c; k++) q.push_back('{en: 8'(1) << (cl + 1), add: AW'(k)});
    for (int k = 0; k < i; k++) q.push_back('{en: 8'h01, add: AW'(k)});
    total = q.size();
    start_stream_in = stream;
    @(negedge clk);
    start_loader      = 1'b1;
    num_entry_state   = AW'(s);
    num_entry_config  = AW'(c);
    num_entry_inbound = AW'(i);
    @(negedge clk);
    start_loader      = 1'b0;
    num_entry_state   = AW'($urandom());
    num_entry_config  = AW'($urandom());
    num_entry_inbound = AW'($urandom());
    pend = 1'b0; acc = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      obs    = {st_wr_en, cfg_wr_en, inb_wr_en};
      exp_en = 8'h00;
      if (pend) begin
        e = q.pop_front();
        d = dq.pop_front();
        exp_en = e.en;
      end
      n_checks++;
      if (obs !== exp_en) begin
        n_fail++;
        $display("FAIL wr_enables beat=%0d got=%b want=%b", acc, obs, exp_en);
      end
      if (pend) begin
        n_checks++;
        if (wr_add !== e.add) begin
          n_fail++;
          $display("FAIL wr_add beat=%0d got=%0d want=%0d", acc, wr_add, e.add);
        end
        n_checks++;
        if (wr_data !== d) begin
          n_fail++;
          $display("FAIL wr_data beat=%0d low word got=%h want=%h", acc, wr_data[31:0], d[31:0]);
        end
      end
      n_checks++;
      if (in_ready !== (acc < total)) begin
        n_fail++;
        $display("FAIL in_ready beat=%0d got=%b want=%b", acc, in_ready, acc < total);
      end
      n_checks++;
      if (ready_stream_in !== ((acc == total) && stream)) begin
        n_fail++;
        $display("FAIL ready_stream_in_load beat=%0d got=%b want=%b", acc, ready_stream_in,
                 (acc == total) && stream);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_load beat=%0d got=%b want=1", acc, busy);
      end
      pend = 1'b0;
      if (abort_at >= 0 && acc == abort_at) begin
        rst = 1'b0;
        #1;
        n_checks++;
        if ({st_wr_en, cfg_wr_en, inb_wr_en, busy, in_ready, ready_stream_in} !== 11'b0) begin
          n_fail++;
          $display("FAIL abort_ctrl got=%b want=0",
                   {st_wr_en, cfg_wr_en, inb_wr_en, busy, in_ready, ready_stream_in});
        end
        n_checks++;
        if (wr_add !== '0 || wr_data !== '0) begin
          n_fail++;
          $display("FAIL abort_wr got add=%0d data_nonzero=%b want 0", wr_add, wr_data != '0);
        end
        in_valid = 1'b0;
        start_stream_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_idle busy got=%b want=0", busy);
        end
        return;
      end
      if (acc == total) begin
        done = 1'b1;
        in_valid = 1'b0;
        start_loader = 1'b0;
      end else begin
        case (vmode)
          0:       in_valid = 1'b1;
          1:       in_valid = (cyc % 2 == 0);
          default: in_valid = ($urandom_range(0, 2) != 0);
        endcase
        in_data      = rnd_phit();
        start_loader = (acc == restart_at);
        num_entry_state   = AW'($urandom());
        num_entry_config  = AW'($urandom());
        num_entry_inbound = AW'($urandom());
        if (in_valid) begin
          pend = 1'b1;
          dq.push_back(in_data);
          acc++;
        end
        cyc++;
        if (cyc > total * 8 + 20) begin
          n_checks++;
          n_fail++;
          $display("FAIL load_timeout accepted=%0d want=%0d", acc, total);
          in_valid = 1'b0;
          rst = 1'b0;
          #1 rst = 1'b1;
          return;
        end
        @(negedge clk);
      end
    end
    // RUN phase and exit back to IDLE
    if (stream) begin
      repeat (3) begin
        @(negedge clk);
        n_checks++;
        if (ready_stream_in !== 1'b1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL run_hold rsi=%b busy=%b want 1 1", ready_stream_in, busy);
        end
      end
      start_stream_in = 1'b0;
      #1;
      n_checks++;
      if (ready_stream_in !== 1'b0) begin
        n_fail++;
        $display("FAIL run_drop rsi got=%b want=0", ready_stream_in);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL run_exit busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({st_wr_en, cfg_wr_en, inb_wr_en, busy, in_ready, ready_stream_in, wr_add} !== '0 ||
        wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got en/status=%b add=%0d", {st_wr_en, cfg_wr_en, inb_wr_en,
               busy, in_ready, ready_stream_in}, wr_add);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_nominal();
    do_load(2, 2, 16, 0, -1, -1, 1'b1);
  endtask

  task automatic test_stream_early();
    start_stream_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (ready_stream_in !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_idle rsi got=%b want=0", ready_stream_in);
      end
    end
    do_load(3, 1, 2, 2, -1, -1, 1'b1);
  endtask

  task automatic test_gaps();
    do_load(1, 2, 2, 1, -1, -1, 1'b0);
  endtask

  task automatic test_zero_counts();
    do_load(0, 0, 3, 0, -1, -1, 1'b0);
    do_load(0, 0, 0, 0, -1, -1, 1'b0);
    do_load(0, 2, 0, 2, -1, -1, 1'b1);
  endtask

  task automatic test_restart();
    do_load(8, 1, 2, 0, 4, -1, 1'b1);
  endtask

  task automatic test_reset_midload();
    do_load(2, 3, 4, 0, -1, 2 + 3 * 3 + 1, 1'b0);
    do_load(2, 3, 4, 2, -1, -1, 1'b1);
  endtask

  task automatic test_max_count();
    do_load(63, 0, 1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_random();
    repeat (6) begin
      do_load($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4), 2, -1, -1,
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stream_early();
    test_gaps();
    test_zero_counts();
    test_restart();
    test_reset_midload();
    test_max_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
